// File: rtl/crt_div_pkg.sv
// Shared constants and width helpers for the constant-divisor datapath.
// Shared by the remainder blocks and the reconstruction side.
package crt_div_pkg;

  localparam int DIVISOR_23 = 23;
  localparam int X_W_16     = 16;

  // Quotient width needed to hold (2**x_w-1)/div.
  function automatic int calc_q_w(input int x_w, input int div);
    return $clog2(((2 ** x_w) - 1) / div + 1);
  endfunction

  localparam int Q_W_16_23 = calc_q_w(X_W_16, DIVISOR_23);
  localparam int R_W_23    = $clog2(DIVISOR_23);

endpackage

// File: rtl/const_mul_add_23.sv
// Combinational shift-add: a + b == q*DIVISOR + r, with no multiplier.
// Set bits of DIVISOR at or above SPLIT go into a; the rest and r go into b.
module const_mul_add_23 #(
  parameter int DIVISOR = 23,
  parameter int Q_W     = 12,
  parameter int R_W     = 5,
  parameter int W       = 17,
  parameter int SPLIT   = 2
) (
  input  logic [Q_W-1:0] q,
  input  logic [R_W-1:0] r,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b
);

  localparam logic [31:0] DIV_V = 32'(DIVISOR);

  logic [W-1:0] qe;
  assign qe = W'(q);

  always_comb begin
    a = '0;
    b = W'(r);
    for (int i = 0; i < 32; i++) begin
      if (DIV_V[i]) begin
        if (i >= SPLIT) a = a + (qe << i);
        else            b = b + (qe << i);
      end
    end
  end

endmodule

// File: rtl/crt_mul_recon_23.sv
// Rebuilds X = Q*DIVISOR + R through a two-stage stallable valid/ready pipe,
// flagging bad remainders and overflow, with a saturating error counter.
module crt_mul_recon_23
  import crt_div_pkg::*;
#(
  parameter int DIVISOR = DIVISOR_23,
  parameter int X_W     = X_W_16,
  parameter int Q_W     = calc_q_w(X_W_16, DIVISOR_23),
  parameter int R_W     = R_W_23,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q_W-1:0]   in_q,
  input  logic [R_W-1:0]   in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   out_x,
  output logic             out_err_rem,
  output logic             out_err_ovf,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_count
);

  localparam int W = X_W + 1;
  localparam logic [R_W-1:0] DIV_R = R_W'(DIVISOR);

  logic         s1_valid, s2_valid;
  logic [W-1:0] s1_a, s1_b;
  logic         s1_rem_bad;
  logic [W-1:0] pa, pb;
  logic [X_W+1:0] sum;
  logic         s1_load, s2_load, out_fire;

  const_mul_add_23 #(
    .DIVISOR(DIVISOR), .Q_W(Q_W), .R_W(R_W), .W(W)
  ) u_mul (
    .q(in_q), .r(in_r), .a(pa), .b(pb)
  );

  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;
  assign sum       = {1'b0, s1_a} + {1'b0, s1_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_rem_bad <= 1'b0;
    end else if (s1_load) begin
      s1_valid   <= 1'b1;
      s1_a       <= pa;
      s1_b       <= pb;
      s1_rem_bad <= (in_r >= DIV_R);
    end else if (s2_load) begin
      s1_valid   <= 1'b0;
    end
  end

  // S2 doubles as the output register; it holds until out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      out_x       <= '0;
      out_err_rem <= 1'b0;
      out_err_ovf <= 1'b0;
    end else if (s2_load) begin
      s2_valid    <= 1'b1;
      out_x       <= sum[X_W-1:0];
      out_err_rem <= s1_rem_bad;
      out_err_ovf <= |sum[X_W+1:X_W];
    end else if (out_ready) begin
      s2_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (clr_count)
      err_count <= '0;
    else if (out_fire && (out_err_rem || out_err_ovf) && (err_count != '1))
      err_count <= err_count + CNT_W'(1);
  end

endmodule

// File: doc/crt_mul_recon_23.md
Name: crt_mul_recon_23

Overview:
- Inverse companion to the constant-divisor remainder blocks: rebuilds the dividend X = Q*DIVISOR + R from a quotient/remainder pair.
- Two-stage, stallable, valid/ready pipeline; constant multiply is done as shift-add with no multiplier.
- Flags out-of-range remainders and result overflow, and keeps a saturating error counter.
- Sits on the output side of the 16-bit divide-by-23 datapath, used for round-trip checking and for reconstruction.

Parameters:
- DIVISOR, 23, constant divisor; must be odd, >= 3, < 2**R_W.
- X_W, 16, reconstructed dividend width.
- Q_W, 12, quotient width (ceil(log2((2**X_W-1)/DIVISOR + 1))).
- R_W, 5, remainder width (ceil(log2(DIVISOR))).
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_q  in  Q_W  quotient.
- in_r  in  R_W  remainder.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_x  out  X_W  reconstructed X, low X_W bits.
- out_err_rem  out  1  in_r >= DIVISOR for this result.
- out_err_ovf  out  1  full sum > 2**X_W-1 for this result.
- err_count  out  CNT_W  saturating count of delivered results with either error flag set.
- clr_count  in  1  synchronous clear of err_count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_x=0, out_err_rem=0, out_err_ovf=0, err_count=0. in_ready=1 while rst is deasserted and the pipe is empty.
- Reset mid-operation: rst asserted while data is in flight drops all in-flight data. No output beat is produced for it.
- Handshake: a transfer happens on a clk edge when valid && ready.
  - Once out_valid rises, out_x and the two flags hold stable until out_ready is seen.
  - in_ready may depend combinationally on out_ready.
  - in_valid does not feed in_ready.
- Stage 1 (S1) register:
  - Captures q, r, a = (q<<4)+(q<<2) and b = (q<<1)+q+r. This decomposition is for DIVISOR=23; the general form is the sum of set-bit shifts of DIVISOR, split into two partial sums.
  - Captures rem_bad = (r >= DIVISOR).
  - All arithmetic is done at X_W+1 bits, zero-extended.
- Stage 2 (S2) register, which is also the output:
  - sum = a + b at X_W+2 bits.
  - out_x = sum[X_W-1:0].
  - out_err_ovf = |sum[X_W+1:X_W].
  - out_err_rem = rem_bad.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load.
  - s2_valid clears when out_ready && !s2_load.
  - Stages fill independently, so bubbles collapse.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 pair per cycle. At most 2 pairs are buffered.
- Full pipe: s1_valid && s2_valid && !out_ready forces in_ready=0. Neither stage changes.
- Ordering: results leave strictly in acceptance order.
- Error counter:
  - Increments on each output transfer with (out_err_rem || out_err_ovf).
  - Saturates at 2**CNT_W-1; no wrap.
  - clr_count has priority over an increment in the same cycle; the result is 0.
- Flags do not suppress data. out_x is still delivered, truncated.

Decomposition:
- Shared package crt_div_pkg:
  - Constants DIVISOR_23 = 23, X_W_16 = 16, and the derived Q_W and R_W widths.
  - A localparam function computing Q_W from X_W and DIVISOR.
- One natural sub-module: const_mul_add_23, a combinational shift-add producing the a/b partial sums. It is reused by the divider self-check.
- The pipeline, handshake and counter stay in the top module.

Test Plan:
- Basic: q=100, r=7, out_ready=1 -> out_x=2307 two cycles after accept; err_rem=0, err_ovf=0, err_count=0.
- Max in-range value: q=2849, r=8 -> out_x=65535, no flags. Then q=2849, r=9 -> out_x=0, err_ovf=1, err_count=1.
- Bad remainder: q=0, r=23 -> out_x=23, err_rem=1. Then q=5, r=31 -> out_x=146, err_rem=1. err_count=2.
- Backpressure:
  - Hold out_ready=0 and offer (1,0), (2,1), (3,2) back-to-back.
  - Only 2 are accepted and in_ready=0 on the third; out_x stays 23.
  - Release out_ready -> 23, 47, 71 in order, no loss or duplication.
- Reset mid-flight: accept (10,3), assert rst the next cycle -> out_valid=0 immediately (async), err_count=0, no 233 beat afterwards.
- Counter: force 2**CNT_W-1 errors -> err_count holds at 65535. clr_count in the same cycle as an error beat -> 0.
